// File: rtl/rat_ckpt.sv
// Register alias table with branch checkpoints.
// Holds a speculative RAT (updated by rename) and a committed RAT (updated by
// retirement), plus NUM_CKPT snapshot slots of the speculative RAT for
// mispredict recovery.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_ren_*                    per-lane rename request (valid, writes rd, arch regs, new phys)
//   o_ren_rs1/rs2_phys         per-lane source mappings (with intra-group bypass)
//   o_ren_pd_old               per-lane prior mapping of rd
//   i_ckpt_req/i_ckpt_lane     snapshot request after the given lane
//   o_ckpt_avail/o_ckpt_id     free slot exists / lowest free slot
//   i_ckpt_free_*              release a slot on correct branch resolution
//   i_restore_*                mispredict recovery from a slot
//   i_flush_valid              copy committed RAT into speculative RAT
//   i_commit_*                 per-lane retirement writes into committed RAT
module rat_ckpt #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned RENAME_W  = 2,
  parameter int unsigned NUM_CKPT  = 4,
  parameter int unsigned PHYS_W    = $clog2(PHYS_REGS),
  parameter int unsigned CKPT_W    = $clog2(NUM_CKPT),
  parameter int unsigned LANE_W    = (RENAME_W > 1) ? $clog2(RENAME_W) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [RENAME_W-1:0]          i_ren_valid,
  input  logic [RENAME_W-1:0]          i_ren_uses_rd,
  input  logic [RENAME_W*5-1:0]        i_ren_rs1_arch,
  input  logic [RENAME_W*5-1:0]        i_ren_rs2_arch,
  input  logic [RENAME_W*5-1:0]        i_ren_rd_arch,
  input  logic [RENAME_W*PHYS_W-1:0]   i_ren_pd_new,
  output logic [RENAME_W*PHYS_W-1:0]   o_ren_rs1_phys,
  output logic [RENAME_W*PHYS_W-1:0]   o_ren_rs2_phys,
  output logic [RENAME_W*PHYS_W-1:0]   o_ren_pd_old,
  input  logic                         i_ckpt_req,
  input  logic [LANE_W-1:0]            i_ckpt_lane,
  output logic                         o_ckpt_avail,
  output logic [CKPT_W-1:0]            o_ckpt_id,
  input  logic                         i_ckpt_free_valid,
  input  logic [CKPT_W-1:0]            i_ckpt_free_id,
  input  logic                         i_restore_valid,
  input  logic [CKPT_W-1:0]            i_restore_id,
  input  logic [NUM_CKPT-1:0]          i_restore_free_mask,
  input  logic                         i_flush_valid,
  input  logic [RENAME_W-1:0]          i_commit_valid,
  input  logic [RENAME_W*5-1:0]        i_commit_rd_arch,
  input  logic [RENAME_W*PHYS_W-1:0]   i_commit_pd
);

  localparam int unsigned AW = 5;

  logic [PHYS_W-1:0]   r_spec [ARCH_REGS];
  logic [PHYS_W-1:0]   r_arch [ARCH_REGS];
  logic [PHYS_W-1:0]   r_ckpt [NUM_CKPT][ARCH_REGS];
  logic [NUM_CKPT-1:0] r_busy;

  logic [AW-1:0]       w_rs1_a [RENAME_W];
  logic [AW-1:0]       w_rs2_a [RENAME_W];
  logic [AW-1:0]       w_rd_a  [RENAME_W];
  logic [PHYS_W-1:0]   w_pd    [RENAME_W];
  logic [RENAME_W-1:0] w_wr;
  logic [AW-1:0]       w_crd_a [RENAME_W];
  logic [PHYS_W-1:0]   w_cpd   [RENAME_W];

  logic [PHYS_W-1:0]   w_spec_ren [ARCH_REGS];
  logic [PHYS_W-1:0]   w_snap     [ARCH_REGS];
  logic [PHYS_W-1:0]   w_arch_nxt [ARCH_REGS];
  logic [NUM_CKPT-1:0] w_busy_nxt;
  logic [NUM_CKPT-1:0] w_free_oh;
  logic [NUM_CKPT-1:0] w_alloc_oh;
  logic                w_alloc;

  // Unpack lane fields; a lane writes only if valid, uses rd and rd is not x0.
  always_comb begin
    w_wr = '0;
    for (int k = 0; k < RENAME_W; k++) begin
      w_rs1_a[k] = i_ren_rs1_arch[k*AW +: AW];
      w_rs2_a[k] = i_ren_rs2_arch[k*AW +: AW];
      w_rd_a[k]  = i_ren_rd_arch[k*AW +: AW];
      w_pd[k]    = i_ren_pd_new[k*PHYS_W +: PHYS_W];
      w_crd_a[k] = i_commit_rd_arch[k*AW +: AW];
      w_cpd[k]   = i_commit_pd[k*PHYS_W +: PHYS_W];
      w_wr[k]    = i_ren_valid[k] & i_ren_uses_rd[k] & (w_rd_a[k] != '0);
    end
  end

  // Combinational reads: older lanes in the same group override the table,
  // scanning oldest to youngest so the youngest older writer wins.
  always_comb begin
    o_ren_rs1_phys = '0;
    o_ren_rs2_phys = '0;
    o_ren_pd_old   = '0;
    for (int k = 0; k < RENAME_W; k++) begin
      logic [PHYS_W-1:0] p1, p2, p3;
      p1 = r_spec[w_rs1_a[k]];
      p2 = r_spec[w_rs2_a[k]];
      p3 = r_spec[w_rd_a[k]];
      for (int j = 0; j < k; j++) begin
        if (w_wr[j] && (w_rd_a[j] == w_rs1_a[k])) p1 = w_pd[j];
        if (w_wr[j] && (w_rd_a[j] == w_rs2_a[k])) p2 = w_pd[j];
        if (w_wr[j] && (w_rd_a[j] == w_rd_a[k]))  p3 = w_pd[j];
      end
      if (w_rs1_a[k] == '0) p1 = '0;
      if (w_rs2_a[k] == '0) p2 = '0;
      if (w_rd_a[k] == '0)  p3 = '0;
      o_ren_rs1_phys[k*PHYS_W +: PHYS_W] = p1;
      o_ren_rs2_phys[k*PHYS_W +: PHYS_W] = p2;
      o_ren_pd_old[k*PHYS_W +: PHYS_W]   = p3;
    end
  end

  // Next speculative state after all lanes, and the snapshot view that only
  // includes lanes up to and including the branch lane.
  always_comb begin
    w_spec_ren = r_spec;
    w_snap     = r_spec;
    for (int l = 0; l < RENAME_W; l++) begin
      if (w_wr[l]) begin
        w_spec_ren[w_rd_a[l]] = w_pd[l];
        if (LANE_W'(l) <= i_ckpt_lane) w_snap[w_rd_a[l]] = w_pd[l];
      end
    end
  end

  always_comb begin
    w_arch_nxt = r_arch;
    for (int l = 0; l < RENAME_W; l++) begin
      if (i_commit_valid[l] && (w_crd_a[l] != '0)) w_arch_nxt[w_crd_a[l]] = w_cpd[l];
    end
  end

  // Lowest free slot: scan downward so the smallest index is the final hit.
  always_comb begin
    o_ckpt_avail = 1'b0;
    o_ckpt_id    = '0;
    for (int s = NUM_CKPT - 1; s >= 0; s--) begin
      if (!r_busy[s]) begin
        o_ckpt_avail = 1'b1;
        o_ckpt_id    = CKPT_W'(s);
      end
    end
  end

  always_comb begin
    w_alloc    = i_ckpt_req & o_ckpt_avail;
    w_free_oh  = i_ckpt_free_valid ? (NUM_CKPT'(1) << i_ckpt_free_id) : '0;
    w_alloc_oh = w_alloc ? (NUM_CKPT'(1) << o_ckpt_id) : '0;
    if (i_flush_valid) begin
      w_busy_nxt = '0;
    end else if (i_restore_valid) begin
      w_busy_nxt = r_busy & ~i_restore_free_mask & ~(NUM_CKPT'(1) << i_restore_id) & ~w_free_oh;
    end else begin
      // Allocation applied after free so a freed-and-reallocated slot stays busy.
      w_busy_nxt = (r_busy & ~w_free_oh) | w_alloc_oh;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_spec[i] <= PHYS_W'(i);
        r_arch[i] <= PHYS_W'(i);
      end
      r_busy <= '0;
    end else begin
      r_arch <= w_arch_nxt;
      r_busy <= w_busy_nxt;
      if (i_flush_valid) begin
        r_spec <= w_arch_nxt;
      end else if (i_restore_valid) begin
        r_spec <= r_ckpt[i_restore_id];
      end else begin
        r_spec <= w_spec_ren;
        if (w_alloc) r_ckpt[o_ckpt_id] <= w_snap;
      end
    end
  end

endmodule

// File: doc/rat_ckpt.md
RAT_CKPT -- requirements
Module: rat_ckpt

Interface
REQ-001 Param ARCH_REGS, default 32, architectural register count (arch index width 5).
REQ-002 Param PHYS_REGS, default 64, physical register count; PHYS_W = $clog2(PHYS_REGS).
REQ-003 Param RENAME_W, default 2, rename/commit lanes per cycle; lane 0 is oldest.
REQ-004 Param NUM_CKPT, default 4, branch checkpoint slots; CKPT_W = $clog2(NUM_CKPT), LANE_W = max(1,$clog2(RENAME_W)).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ren_valid / ren_uses_rd  in  RENAME_W each  lane valid / lane writes rd.
REQ-009 ren_rs1_arch, ren_rs2_arch, ren_rd_arch  in  RENAME_W*5  source/dest arch regs.
REQ-010 ren_pd_new  in  RENAME_W*PHYS_W  newly allocated phys reg per lane.
REQ-011 ren_rs1_phys, ren_rs2_phys, ren_pd_old  out  RENAME_W*PHYS_W  source mappings; prior rd mapping.
REQ-012 ckpt_req  in  1, ckpt_lane  in  LANE_W  snapshot request and branch lane.
REQ-013 ckpt_avail  out  1, ckpt_id  out  CKPT_W  free slot exists; slot granted on ckpt_req.
REQ-014 ckpt_free_valid  in  1, ckpt_free_id  in  CKPT_W  branch resolved correct; release slot.
REQ-015 restore_valid  in  1, restore_id  in  CKPT_W, restore_free_mask  in  NUM_CKPT  mispredict recovery.
REQ-016 flush_valid  in  1  full flush to committed state.
REQ-017 commit_valid  in  RENAME_W, commit_rd_arch  in  RENAME_W*5, commit_pd  in  RENAME_W*PHYS_W  retirement updates.

Function
REQ-018 Two tables: speculative RAT (spec) and committed RAT (arch); each ARCH_REGS x PHYS_W.
REQ-019 Reads combinational: lane k rs1/rs2/pd_old = spec entry, overridden by youngest lane j<k with ren_valid&ren_uses_rd and matching rd (intra-group bypass).
REQ-020 Arch reg 0 never remapped: reads of x0 return 0; writes to rd=0 ignored on rename, commit, checkpoint.
REQ-021 Rename write: at clk edge, spec[rd] <= pd_new for each valid writing lane; same rd in several lanes -> highest lane wins.
REQ-022 Commit write: arch[commit_rd_arch] <= commit_pd per valid lane, highest lane wins; commit applies every cycle regardless of flush/restore.
REQ-023 Checkpoint slot free bitmap; ckpt_id = lowest free slot index; ckpt_avail = any slot free.
REQ-024 ckpt_req with ckpt_avail=1: slot ckpt_id <= spec after lanes 0..ckpt_lane applied (lanes > ckpt_lane excluded); slot marked busy; ckpt_req with ckpt_avail=0 ignored (upstream stalls).
REQ-025 ckpt_free_valid: slot ckpt_free_id marked free next cycle; freeing a free slot is a no-op.
REQ-026 restore_valid: spec <= snapshot[restore_id]; slot restore_id and all slots in restore_free_mask freed; same-cycle rename writes and ckpt_req dropped.
REQ-027 flush_valid: spec <= next-state arch (including same-cycle commit writes); all checkpoint slots freed; rename, ckpt_req, restore dropped.
REQ-028 Priority: rst > flush_valid > restore_valid > rename/ckpt_req; ckpt_free_valid applied alongside restore and rename, same-cycle alloc of a slot being freed keeps it busy.
REQ-029 Latency: writes visible to combinational reads the cycle after the edge; no stall outputs besides ckpt_avail.

Reset
REQ-030 On rst: spec[i] = arch[i] = i for all i; all checkpoint slots free; ckpt_avail=1, ckpt_id=0; reads reflect identity map next cycle.
REQ-031 rst mid-operation discards all in-flight rename, commit, checkpoint and restore effects of that cycle.

Verification
REQ-032 Reset, read rs1=5,rs2=7 -> rs1_phys=5, rs2_phys=7, ckpt_avail=1, ckpt_id=0.
REQ-033 Lane0 rd=3 pd=40, lane1 rs1=3 same cycle -> lane1 rs1_phys=40, lane1 pd_old (rd=3) =40; next cycle spec[3]=40.
REQ-034 Rename rd=4->41 with ckpt_req lane0 (slot 0), then rd=4->42; restore_valid id=0 -> rs1=4 reads 41, slot 0 free, ckpt_id=0.
REQ-035 Allocate 4 checkpoints -> ckpt_avail=0; ckpt_req ignored; ckpt_free_id=2 -> ckpt_avail=1, ckpt_id=2.
REQ-036 Commit rd=6 pd=50, rename rd=6->51, flush_valid with commit rd=7 pd=52 same cycle -> spec[6]=50, spec[7]=52, all slots free.
REQ-037 Rename rd=0 pd=60 and commit rd=0 -> rs1=0 reads 0; spec/arch unchanged.
